// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: parses a counted, XOR-checksummed image,
// writes it word by word and holds the core in reset until the image is verified.
module imem_loader #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   output logic              load_done,
   output logic              load_error
);

   typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, CHECK, DONE, ERROR} state_t;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t          state;
   logic [7:0]      count_lo;
   logic [7:0]      csum;
   logic [ADDR_W:0] word_idx;
   logic [ADDR_W:0] word_cnt;
   logic [ADDR_W:0] word_idx_nxt;
   logic [1:0]      byte_idx;
   logic [23:0]     word_buf;
   logic [16:0]     n_words;
   logic            accept;

   assign accept       = rx_valid && rx_ready;
   assign n_words      = {1'b0, rx_data, count_lo};
   assign word_idx_nxt = word_idx + {{ADDR_W{1'b0}}, 1'b1};

   always_comb begin
      rx_ready = 1'b0;
      case (state)
         HDR_LO, HDR_HI, DATA, CHECK: rx_ready = 1'b1;
         default:                     rx_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= HDR_LO;
         count_lo   <= '0;
         csum       <= '0;
         word_idx   <= '0;
         word_cnt   <= '0;
         byte_idx   <= '0;
         word_buf   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_reset <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (accept) begin
            case (state)
               HDR_LO: begin
                  count_lo <= rx_data;
                  state    <= HDR_HI;
               end
               HDR_HI: begin
                  if (n_words == '0) begin
                     state <= CHECK;
                  end else if (n_words > DEPTH_L) begin
                     state      <= ERROR;
                     load_error <= 1'b1;
                  end else begin
                     word_cnt <= n_words[ADDR_W:0];
                     word_idx <= '0;
                     byte_idx <= '0;
                     state    <= DATA;
                  end
               end
               DATA: begin
                  // Bytes enter at the top so byte 0 ends up in bits [7:0].
                  csum     <= csum ^ rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  word_buf <= {rx_data, word_buf[23:8]};
                  if (byte_idx == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= word_idx[ADDR_W-1:0];
                     imem_wdata <= {rx_data, word_buf};
                     word_idx   <= word_idx_nxt;
                     if (word_idx_nxt == word_cnt)
                        state <= CHECK;
                  end
               end
               CHECK: begin
                  if (rx_data == csum) begin
                     state      <= DONE;
                     core_reset <= 1'b0;
                     load_done  <= 1'b1;
                  end else begin
                     state      <= ERROR;
                     load_error <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, empty, bad checksum, oversize,
// full-depth, stalled and reset-interrupted image loads.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        core_reset;
   logic        load_done;
   logic        load_error;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic        prev_we  = 1'b0;
   int unsigned we_long  = 0;

   logic [7:0] nom[11] = '{8'h02, 8'h00, 8'hb3, 8'h03, 8'h53, 8'h00,
                           8'h33, 8'h86, 8'h62, 8'h00, 8'h34};

   imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .core_reset(core_reset),
      .load_done(load_done), .load_error(load_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr.push_back({24'h0, imem_addr});
         wr_data.push_back(imem_wdata);
         if (prev_we) we_long++;
      end
      prev_we <= imem_we;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int unsigned guard = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!rx_ready) check("ready_timeout", 32'(rx_ready), 32'h1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      reset    = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(1);
      wr_addr.delete();
      wr_data.delete();
      we_long = 0;
   endtask

   function automatic logic [31:0] log_addr(input int unsigned k);
      return (wr_addr.size() > k) ? wr_addr[k] : 32'hdead_beef;
   endfunction

   function automatic logic [31:0] log_data(input int unsigned k);
      return (wr_data.size() > k) ? wr_data[k] : 32'hdead_beef;
   endfunction

   task automatic check_nominal_writes(input string tag);
      check({tag, "_nwr"},   32'(wr_addr.size()), 32'd2);
      check({tag, "_a0"},    log_addr(0), 32'd0);
      check({tag, "_d0"},    log_data(0), 32'h0053_03b3);
      check({tag, "_a1"},    log_addr(1), 32'd1);
      check({tag, "_d1"},    log_data(1), 32'h0062_8633);
      check({tag, "_welen"}, 32'(we_long), 32'd0);
   endtask

   initial begin
      logic [7:0] x;
      logic [7:0] b;
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(2);
      check("rst_ready",  32'(rx_ready),   32'h1);
      check("rst_we",     32'(imem_we),    32'h0);
      check("rst_addr",   32'(imem_addr),  32'h0);
      check("rst_wdata",  imem_wdata,      32'h0);
      check("rst_corers", 32'(core_reset), 32'h1);
      check("rst_done",   32'(load_done),  32'h0);
      check("rst_err",    32'(load_error), 32'h0);
      reset = 1'b0;
      idle(1);

      // Nominal load, back to back
      for (int i = 0; i < 10; i++) begin
         send(nom[i]);
         if (i == 5) begin
            check("nom_we_w0",    32'(imem_we),   32'h1);
            check("nom_addr_w0",  32'(imem_addr), 32'h0);
            check("nom_wdata_w0", imem_wdata,     32'h0053_03b3);
         end
      end
      check("nom_pre_done",   32'(load_done),  32'h0);
      check("nom_pre_corers", 32'(core_reset), 32'h1);
      send(nom[10]);
      check("nom_done",   32'(load_done),  32'h1);
      check("nom_corers", 32'(core_reset), 32'h0);
      check("nom_err",    32'(load_error), 32'h0);
      check("nom_ready",  32'(rx_ready),   32'h0);
      idle(2);
      check_nominal_writes("nom");

      // Empty image
      do_reset();
      send(8'h00); send(8'h00); send(8'h00);
      check("empty_done",   32'(load_done),  32'h1);
      check("empty_corers", 32'(core_reset), 32'h0);
      idle(2);
      check("empty_nwr",    32'(wr_addr.size()), 32'd0);

      // Bad checksum
      do_reset();
      for (int i = 0; i < 10; i++) send(nom[i]);
      send(8'h35);
      check("bad_err",    32'(load_error), 32'h1);
      check("bad_done",   32'(load_done),  32'h0);
      check("bad_corers", 32'(core_reset), 32'h1);
      check("bad_ready",  32'(rx_ready),   32'h0);
      idle(2);
      check("bad_nwr",    32'(wr_addr.size()), 32'd2);

      // Oversize count N=257
      do_reset();
      send(8'h01);
      check("ovs_err_lo", 32'(load_error), 32'h0);
      send(8'h01);
      check("ovs_err",    32'(load_error), 32'h1);
      check("ovs_ready",  32'(rx_ready),   32'h0);
      check("ovs_corers", 32'(core_reset), 32'h1);
      idle(2);
      check("ovs_nwr",    32'(wr_addr.size()), 32'd0);

      // Full depth N=256 is legal
      do_reset();
      send(8'h00); send(8'h01);
      check("full_hdr_err",   32'(load_error), 32'h0);
      check("full_hdr_ready", 32'(rx_ready),   32'h1);
      x = 8'h00;
      for (int i = 0; i < 1024; i++) begin
         b = 8'((i * 7 + 3) & 255);
         x = x ^ b;
         send(b);
      end
      send(x);
      check("full_done", 32'(load_done), 32'h1);
      idle(2);
      check("full_nwr",   32'(wr_addr.size()), 32'd256);
      check("full_alast", log_addr(255), 32'd255);
      // word 255 bytes: i=1020..1023 -> (i*7+3)&255
      check("full_dlast", log_data(255),
            {8'(((1023 * 7) + 3) & 255), 8'(((1022 * 7) + 3) & 255),
             8'(((1021 * 7) + 3) & 255), 8'(((1020 * 7) + 3) & 255)});
      check("full_welen", 32'(we_long), 32'd0);

      // Stalls: valid pattern 1,0,0,1
      do_reset();
      for (int i = 0; i < 11; i++) begin
         send(nom[i]);
         if (i % 2 == 0) idle(2);
      end
      check("stall_done",   32'(load_done),  32'h1);
      check("stall_corers", 32'(core_reset), 32'h0);
      idle(2);
      check_nominal_writes("stall");

      // Reset mid-word, bytes offered during reset must be ignored
      do_reset();
      send(nom[0]); send(nom[1]); send(nom[2]); send(nom[3]);
      rx_valid = 1'b1;
      rx_data  = 8'h01;
      reset    = 1'b1;
      #1;
      check("mid_rst_we",     32'(imem_we),    32'h0);
      check("mid_rst_corers", 32'(core_reset), 32'h1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      reset    = 1'b0;
      wr_addr.delete();
      wr_data.delete();
      we_long = 0;
      for (int i = 0; i < 11; i++) send(nom[i]);
      check("mid_done", 32'(load_done),  32'h1);
      check("mid_err",  32'(load_error), 32'h0);
      idle(2);
      check_nominal_writes("mid");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes instruction memory through its write port, so instruction memory is not preloaded by testbench backdoor writes. It sits between a byte source (UART receiver or bench driver) and the instruction fetch unit's memory. It holds `riscv_processor` in reset until a complete, checksum-verified image is committed, then releases it so the core fetches from PC 0.

## Interface
Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words.
- ADDR_W, 8, word-address width; must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; returns the block to HDR_LO immediately.
- rx_valid  in  1  source has a byte on rx_data.
- rx_data  in  8  byte payload.
- rx_ready  out  1  loader can accept a byte; a byte transfers on a rising edge where rx_valid && rx_ready.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- core_reset  out  1  drives `riscv_processor` reset; high until load succeeds.
- load_done  out  1  image committed and verified.
- load_error  out  1  image rejected.

## Operation
- Stream format:
  - count_lo, count_hi: 16-bit word count N, little-endian.
  - 4*N data bytes: each word little-endian; byte i of a word lands in bits [8i+7:8i].
  - One checksum byte: XOR of all 4*N data bytes. Header bytes are excluded from the checksum.
- States:
  - HDR_LO: accept count_lo, go to HDR_HI.
  - HDR_HI: accept count_hi. If N==0, go to CHECK. If N>DEPTH, go to ERROR. Otherwise go to DATA with word_idx=0 and byte_idx=0.
  - DATA: each accepted byte is shifted into the word buffer and XORed into the running checksum; byte_idx increments mod 4. On the 4th byte: register a write of the buffer to word_idx, then increment word_idx. After word N-1, go to CHECK.
  - CHECK: accept one byte. Go to DONE if it equals the running checksum, else to ERROR.
  - DONE, ERROR: terminal until reset.
- rx_ready = 1 in HDR_LO, HDR_HI, DATA, CHECK; 0 in DONE and ERROR. It is a combinational state decode.
- Words already written stay in memory after an error. The core stays in reset.
- word_idx is ADDR_W+1 bits wide, so N==DEPTH is legal without wrap. imem_addr = word_idx[ADDR_W-1:0].

## Timing
- Reset values: state HDR_LO, rx_ready 1, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, load_done 0, load_error 0. Checksum, word_idx and byte_idx are 0.
- No byte is accepted while reset is high.
- Throughput is 1 byte per cycle with no bubbles. rx_ready is not lowered during write cycles.
- Write latency:
  - imem_we, imem_addr and imem_wdata are registered at the edge that accepts a word's 4th byte.
  - imem_we is high for exactly the following cycle. Memory samples it on the next edge.
- core_reset falls and load_done rises on the same edge that accepts a matching checksum byte.
- With back-to-back bytes, the final word's write commits on that same edge. The core's first fetch is therefore always after the last write.
- load_error rises on the edge that accepts a bad checksum, or the count_hi that makes N>DEPTH.
- Gaps in rx_valid stall the state machine with no state change. imem_we never stays asserted for more than one cycle.
- Reset mid-operation:
  - imem_we and all state clear asynchronously and any partial word is discarded.
  - core_reset returns to 1; load_done and load_error clear.
  - A fresh stream is then accepted from HDR_LO.

## Test plan
- Nominal load: stream 02 00, b3 03 53 00, 33 86 62 00, 34.
  - imem_we pulses with addr 0 / 0x005303b3, then addr 1 / 0x00628633.
  - load_done=1 and core_reset=0 after the 11th byte.
  - With x5=1 and x6=2 preset, the core then writes x7=3 and x12=3.
- Empty image: stream 00 00, 00 -> no imem_we pulse; DONE after 3 bytes; core_reset=0.
- Bad checksum: the nominal stream with a final byte of 35 -> both writes occur, then load_error=1, core_reset stays 1, rx_ready=0.
- Oversize count: stream 01 01 (N=257) -> load_error=1 on the edge accepting 0x01 (count_hi). rx_ready=0 and no writes occur.
- Stalls and backpressure: the nominal stream with rx_valid toggling 1,0,0,1 -> identical writes and result; each imem_we pulse is exactly 1 cycle.
- Reset mid-word: after b3 03, pulse reset for 1 cycle, then send the full nominal stream -> first write is addr 0 / 0x005303b3 and load_done=1.
